// File: rtl/ps2_rx_scancode_fifo_pkg.sv
// Shared constants for the PS/2 receive path: FSM encoding, frame geometry, error bits, inhibit hold.
package ps2_rx_scancode_fifo_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int PS2_DATA_BITS = 8;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;

    // 100 us at 83.333 MHz
    localparam int PS2_INHIBIT_HOLD = 8334;

    // PS/2 uses odd parity across the eight data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_scancode_fifo_if.sv
// CPU-side register view of the scan-code FIFO: pop/clear strobes in, head/count/errors out.
interface ps2_rx_scancode_fifo_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          pop;
    logic          error_clear;
    logic [7:0]    head_data;
    logic          not_empty;
    logic [CW-1:0] fifo_count;
    logic [1:0]    error_sticky;

    modport master (
        output pop, error_clear,
        input  head_data, not_empty, fifo_count, error_sticky
    );

    modport slave (
        input  pop, error_clear,
        output head_data, not_empty, fifo_count, error_sticky
    );
endinterface

// File: rtl/ps2_rx_scancode_fifo_line_filter.sv
// 2-flop synchronizer plus FILTER_LEN-sample glitch filter for one PS/2 line; level resets to 1.
// Latency 2+FILTER_LEN cycles from pin change to filtered change; fall_o pulses with the 1->0 change.
module ps2_rx_scancode_fifo_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1_q, sync2_q, level_q, fall_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, flip;

    assign differ = (sync2_q != level_q);
    assign flip   = differ && (cnt_q == CW'(FILTER_LEN - 1));

    always_comb begin
        cnt_d = '0;
        if (differ && !flip) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            fall_q  <= flip && level_q;
            if (flip) level_q <= ~level_q;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/ps2_rx_scancode_fifo.sv
// PS/2 device-to-host receiver: deframes 11-bit frames into a FIFO drained by CPU pop strobes.
// Byte visible one cycle after the stop-bit clock fall; PS/2 clock held low while the FIFO is full.
module ps2_rx_scancode_fifo
    import ps2_rx_scancode_fifo_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 166667,
    parameter int FIFO_DEPTH     = 8,
    parameter int INHIBIT_HOLD   = PS2_INHIBIT_HOLD
) (
    input  logic main_clk,
    input  logic main_reset_n,
    input  logic ps2_external_clock_in,
    input  logic ps2_external_data_in,
    output logic ps2_external_clock_pulldown,
    output logic ps2_external_data_pulldown,
    ps2_rx_scancode_fifo_if.slave cpu
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(INHIBIT_HOLD + 1);

    logic rst_meta_q, rst_n_q;

    // Reset asserts immediately but releases synchronously to main_clk
    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    logic clk_lvl_unused, clk_fall, dat_lvl, data_fall_unused;

    ps2_rx_scancode_fifo_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(main_clk), .rst_n(rst_n_q), .raw_i(ps2_external_clock_in),
        .level_o(clk_lvl_unused), .fall_o(clk_fall)
    );

    ps2_rx_scancode_fifo_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk(main_clk), .rst_n(rst_n_q), .raw_i(ps2_external_data_in),
        .level_o(dat_lvl), .fall_o(data_fall_unused)
    );

    logic [1:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_req, set_par, set_frm;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_q, head_d;
    logic          full, do_push, do_pop, drop;

    logic          inhibit_q, inhibit_d, inhibit;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    err_q, err_d;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign inhibit = inhibit_q || full;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        push_req = 1'b0;
        set_par  = 1'b0;
        set_frm  = 1'b0;
        if (inhibit) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else if (clk_fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat_lvl) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_lvl, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_lvl;
                    state_d = ST_STOP;
                end
                default: begin
                    // Bad stop bit outranks a parity error
                    state_d = ST_IDLE;
                    if (!dat_lvl)                            set_frm  = 1'b1;
                    else if (!odd_parity_ok(shift_q, par_q)) set_par  = 1'b1;
                    else                                     push_req = 1'b1;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                set_frm = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign do_push  = push_req && !full;
    assign drop     = push_req && full;
    assign do_pop   = cpu.pop && (count_q != '0);
    assign wr_ptr_d = wr_ptr_q + AW'(do_push);
    assign rd_ptr_d = rd_ptr_q + AW'(do_pop);
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);
    // Pushing into an (about to be) empty FIFO bypasses the array so head tracks the new byte
    assign head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];

    always_comb begin
        inhibit_d = inhibit_q;
        hold_d    = hold_q;
        if (!inhibit_q) begin
            if (full) begin
                inhibit_d = 1'b1;
                hold_d    = '0;
            end
        end else if (hold_q != HW'(INHIBIT_HOLD - 1)) begin
            hold_d = hold_q + HW'(1);
        end else if (!full) begin
            inhibit_d = 1'b0;
        end
    end

    always_comb begin
        err_d = cpu.error_clear ? 2'b00 : err_q;
        if (set_par)         err_d[ERR_PARITY] = 1'b1;
        if (set_frm || drop) err_d[ERR_FRAME]  = 1'b1;
    end

    always_ff @(posedge main_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge main_clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            inhibit_q <= 1'b0;
            hold_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            inhibit_q <= inhibit_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
        end
    end

    assign ps2_external_clock_pulldown = inhibit;
    assign ps2_external_data_pulldown  = 1'b0;
    assign cpu.head_data               = head_q;
    assign cpu.not_empty               = (count_q != '0);
    assign cpu.fifo_count              = count_q;
    assign cpu.error_sticky            = err_q;
endmodule
